// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin mux arbiter.
// The lock signal exists only when MUX_ARB_LOCK_EN is defined.
interface mux_rr_arbiter_if;
  logic [7:0] req;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       valid;
`ifdef MUX_ARB_LOCK_EN
  logic       lock;
`endif

  modport master (
    output req,
`ifdef MUX_ARB_LOCK_EN
    output lock,
`endif
    input  sel,
    input  grant,
    input  valid
  );

  modport slave (
    input  req,
`ifdef MUX_ARB_LOCK_EN
    input  lock,
`endif
    output sel,
    output grant,
    output valid
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the registered 8:1 bit mux: IDLE -> SETTLE -> OWN.
// Optional MUX_ARB_LOCK_EN adds a lock input that lets an owner exceed MAX_HOLD.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  mux_rr_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OWN    = 2'd2
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [7:0]        grant_q, grant_d;
  logic              valid_q, valid_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]        last_ptr_q, last_ptr_d;

  logic              found;
  logic [2:0]        winner;
  logic [2:0]        idx;
  logic              req_sel;
  logic              hold_at_max;
  logic              release_own;

  // Scan last_ptr+1 .. last_ptr+8 so the previous owner is considered last.
  always_comb begin
    found  = 1'b0;
    winner = 3'd0;
    idx    = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      idx = last_ptr_q + 3'(i);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign req_sel     = bus.req[sel_q];
  assign hold_at_max = (hold_cnt_q == HOLD_LAST);
`ifdef MUX_ARB_LOCK_EN
  assign release_own = !req_sel || (!bus.lock && hold_at_max);
`else
  assign release_own = !req_sel || hold_at_max;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    valid_d    = valid_q;
    hold_cnt_d = hold_cnt_q;
    last_ptr_d = last_ptr_q;
    case (state_q)
      IDLE: begin
        grant_d = 8'h00;
        valid_d = 1'b0;
        if (found) begin
          sel_d   = winner;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (req_sel) begin
          state_d    = OWN;
          grant_d    = 8'h01 << sel_q;
          valid_d    = 1'b1;
          hold_cnt_d = '0;
        end else begin
          // A requester that vanished during SETTLE forfeits its turn.
          state_d    = IDLE;
          grant_d    = 8'h00;
          valid_d    = 1'b0;
          last_ptr_d = sel_q;
        end
      end
      OWN: begin
        if (release_own) begin
          state_d    = IDLE;
          grant_d    = 8'h00;
          valid_d    = 1'b0;
          last_ptr_d = sel_q;
        end else begin
          hold_cnt_d = hold_at_max ? hold_cnt_q : hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'h00;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      sel_q      <= 3'd0;
      grant_q    <= 8'h00;
      valid_q    <= 1'b0;
      hold_cnt_q <= '0;
      last_ptr_q <= 3'd7;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      hold_cnt_q <= hold_cnt_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.grant = grant_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a per-cycle vector table plus hand sequences
// for round-robin rotation, reset during OWN and (with MUX_ARB_LOCK_EN) lock.
module tb_mux_rr_arbiter;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       valid;
  } vec_t;

  localparam int NUM_VECS = 31;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs [NUM_VECS];

  mux_rr_arbiter_if bus ();

  mux_rr_arbiter #(
    .MAX_HOLD (4),
    .HOLD_W   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [7:0] q);
    rst     = r;
    bus.req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] exp_sel,
                             input logic [7:0] exp_grant, input logic exp_valid);
    checks++;
    if (bus.sel !== exp_sel || bus.grant !== exp_grant || bus.valid !== exp_valid) begin
      failures++;
      $display("[TB] FAIL %s: got sel=%0d grant=%02h valid=%b, expected sel=%0d grant=%02h valid=%b",
               name, bus.sel, bus.grant, bus.valid, exp_sel, exp_grant, exp_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.req  = 8'h00;
`ifdef MUX_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif

    // Reset under noise, idle, single requester, drop in OWN, drop in SETTLE.
    vecs[0]  = '{1'b0, 8'hA5, 3'd0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 8'h5A, 3'd0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 8'h00, 3'd0, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 8'h00, 3'd0, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 8'h01, 3'd0, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 8'h01, 3'd0, 8'h01, 1'b1};
    vecs[6]  = '{1'b1, 8'h01, 3'd0, 8'h01, 1'b1};
    vecs[7]  = '{1'b1, 8'h01, 3'd0, 8'h01, 1'b1};
    vecs[8]  = '{1'b1, 8'h01, 3'd0, 8'h01, 1'b1};
    vecs[9]  = '{1'b1, 8'h01, 3'd0, 8'h00, 1'b0};
    vecs[10] = '{1'b1, 8'h01, 3'd0, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 8'h01, 3'd0, 8'h01, 1'b1};
    vecs[12] = '{1'b1, 8'h00, 3'd0, 8'h00, 1'b0};
    vecs[13] = '{1'b1, 8'h00, 3'd0, 8'h00, 1'b0};
    vecs[14] = '{1'b1, 8'h24, 3'd2, 8'h00, 1'b0};
    vecs[15] = '{1'b1, 8'h24, 3'd2, 8'h04, 1'b1};
    vecs[16] = '{1'b1, 8'h24, 3'd2, 8'h04, 1'b1};
    vecs[17] = '{1'b1, 8'h20, 3'd2, 8'h00, 1'b0};
    vecs[18] = '{1'b1, 8'h20, 3'd5, 8'h00, 1'b0};
    vecs[19] = '{1'b1, 8'h20, 3'd5, 8'h20, 1'b1};
    vecs[20] = '{1'b1, 8'h00, 3'd5, 8'h00, 1'b0};
    vecs[21] = '{1'b1, 8'h10, 3'd4, 8'h00, 1'b0};
    vecs[22] = '{1'b1, 8'h00, 3'd4, 8'h00, 1'b0};
    vecs[23] = '{1'b1, 8'h11, 3'd0, 8'h00, 1'b0};
    vecs[24] = '{1'b1, 8'h11, 3'd0, 8'h01, 1'b1};
    vecs[25] = '{1'b1, 8'h00, 3'd0, 8'h00, 1'b0};
    vecs[26] = '{1'b1, 8'h10, 3'd4, 8'h00, 1'b0};
    vecs[27] = '{1'b1, 8'h00, 3'd4, 8'h00, 1'b0};
    vecs[28] = '{1'b1, 8'h30, 3'd5, 8'h00, 1'b0};
    vecs[29] = '{1'b1, 8'h30, 3'd5, 8'h20, 1'b1};
    vecs[30] = '{1'b1, 8'h00, 3'd5, 8'h00, 1'b0};

    for (int v = 0; v < NUM_VECS; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].req);
      checkOutput($sformatf("vec%0d", v), vecs[v].sel, vecs[v].grant, vecs[v].valid);
    end

    // All requesting: strict rotation 0..7 then 0 again, 4 OWN cycles, 2 dead cycles.
    applyStimulus(1'b0, 8'hFF);
    checkOutput("rr_reset", 3'd0, 8'h00, 1'b0);
    for (int k = 0; k < 9; k++) begin
      logic [2:0] who;
      who = 3'(k % 8);
      applyStimulus(1'b1, 8'hFF);
      checkOutput($sformatf("rr%0d_settle", k), who, 8'h00, 1'b0);
      for (int c = 0; c < 4; c++) begin
        applyStimulus(1'b1, 8'hFF);
        checkOutput($sformatf("rr%0d_own%0d", k, c), who, 8'h01 << who, 1'b1);
      end
      applyStimulus(1'b1, 8'hFF);
      checkOutput($sformatf("rr%0d_release", k), who, 8'h00, 1'b0);
    end

    // Reset asserted in the third OWN cycle of owner 1.
    applyStimulus(1'b1, 8'hFF);
    checkOutput("rst_own_settle", 3'd1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hFF);
    checkOutput("rst_own_c1", 3'd1, 8'h02, 1'b1);
    applyStimulus(1'b1, 8'hFF);
    checkOutput("rst_own_c2", 3'd1, 8'h02, 1'b1);
    applyStimulus(1'b0, 8'hFF);
    checkOutput("rst_own_drop", 3'd0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h81);
    checkOutput("rst_after_sel", 3'd0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h81);
    checkOutput("rst_after_grant", 3'd0, 8'h01, 1'b1);

`ifdef MUX_ARB_LOCK_EN
    // Lock keeps requester 0 beyond MAX_HOLD; clearing it releases next edge.
    applyStimulus(1'b0, 8'h00);
    checkOutput("lock_reset", 3'd0, 8'h00, 1'b0);
    bus.lock = 1'b1;
    applyStimulus(1'b1, 8'h03);
    checkOutput("lock_settle", 3'd0, 8'h00, 1'b0);
    for (int c = 0; c < 11; c++) begin
      applyStimulus(1'b1, 8'h03);
      checkOutput($sformatf("lock_own%0d", c), 3'd0, 8'h01, 1'b1);
    end
    bus.lock = 1'b0;
    applyStimulus(1'b1, 8'h03);
    checkOutput("lock_release", 3'd0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h03);
    checkOutput("lock_next_sel", 3'd1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h03);
    checkOutput("lock_next_grant", 3'd1, 8'h02, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
